mem_wb_stage: RTL and testbench

- Memory-access and writeback stage that sits directly downstream of the ALU.
- Consumes the ALU result, register-write flag, PC-write flag and memory mode.
- Runs a req/ack transaction on the data-memory port when the memory mode calls for it.
- Delivers exactly one writeback pulse per accepted operation to the register file and PC; O_busy stalls upstream while an operation is in flight.

---
 rtl/mem_wb_if.sv | 38 +++
 rtl/mem_wb_stage.sv | 138 +++++++++++++
 tb/tb_mem_wb_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// mem_wb_if: upstream, data-memory and writeback signals of the memory/writeback stage
interface mem_wb_if #(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 3
);
  logic                 I_enable;
  logic [DATA_W-1:0]    I_alu_out;
  logic                 I_write_rD;
  logic                 I_write_pc;
  logic [1:0]           I_memory_mode;
  logic [REG_SEL_W-1:0] I_rD_sel;
  logic [DATA_W-1:0]    I_store_data;
  logic                 O_mem_req;
  logic                 O_mem_we;
  logic [DATA_W-1:0]    O_mem_addr;
  logic [DATA_W-1:0]    O_mem_wdata;
  logic                 I_mem_ack;
  logic [DATA_W-1:0]    I_mem_rdata;
  logic                 O_rD_we;
  logic [REG_SEL_W-1:0] O_rD_sel;
  logic [DATA_W-1:0]    O_rD_data;
  logic                 O_pc_we;
  logic [DATA_W-1:0]    O_pc_data;
  logic                 O_busy;
  logic                 O_fault;
  modport master (
    output I_enable, I_alu_out, I_write_rD, I_write_pc, I_memory_mode, I_rD_sel, I_store_data,
    output I_mem_ack, I_mem_rdata,
    input  O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
    input  O_rD_we, O_rD_sel, O_rD_data, O_pc_we, O_pc_data, O_busy, O_fault
  );
  modport slave (
    input  I_enable, I_alu_out, I_write_rD, I_write_pc, I_memory_mode, I_rD_sel, I_store_data,
    input  I_mem_ack, I_mem_rdata,
    output O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
    output O_rD_we, O_rD_sel, O_rD_data, O_pc_we, O_pc_data, O_busy, O_fault
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access + writeback stage; optional request timeout under MEM_WB_TIMEOUT_EN
module mem_wb_stage #(
  parameter int DATA_W         = 16,
  parameter int REG_SEL_W      = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic     I_clk,
  input logic     I_reset,
  mem_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
  state_t               state_q, state_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic                 rd_we_q, rd_we_d, pc_we_q, pc_we_d;
  logic [REG_SEL_W-1:0] rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d, pc_data_q, pc_data_d;
  logic                 busy_q, busy_d, fault_q, fault_d;
  logic                 wr_rd_q, wr_rd_d, wr_pc_q, wr_pc_d, is_read_q, is_read_d;
`ifdef MEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
  wire is_mem_op = (bus.I_memory_mode == 2'd1) || (bus.I_memory_mode == 2'd2);
  // next-state and registered-output computation; pulses default low
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_we_d   = 1'b0;
    pc_we_d   = 1'b0;
    rd_sel_d  = rd_sel_q;
    rd_data_d = rd_data_q;
    pc_data_d = pc_data_q;
    fault_d   = fault_q;
    wr_rd_d   = wr_rd_q;
    wr_pc_d   = wr_pc_q;
    is_read_d = is_read_q;
`ifdef MEM_WB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.I_enable) begin
        wr_rd_d   = bus.I_write_rD;
        wr_pc_d   = bus.I_write_pc;
        is_read_d = bus.I_memory_mode == 2'd1;
        rd_sel_d  = bus.I_rD_sel;
        pc_data_d = bus.I_alu_out;
        if (is_mem_op) begin
          state_d = MEM;
          req_d   = 1'b1;
          we_d    = bus.I_memory_mode == 2'd2;
          addr_d  = bus.I_alu_out;
          wdata_d = bus.I_store_data;
`ifdef MEM_WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d   = WB;
          rd_data_d = bus.I_alu_out;
          rd_we_d   = bus.I_write_rD;
          pc_we_d   = bus.I_write_pc;
        end
      end
      MEM: if (bus.I_mem_ack) begin
        state_d   = WB;
        req_d     = 1'b0;
        rd_data_d = is_read_q ? bus.I_mem_rdata : rd_data_q;
        rd_we_d   = wr_rd_q;
        pc_we_d   = wr_pc_q;
      end
`ifdef MEM_WB_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        req_d   = 1'b0;
        fault_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_we_q   <= 1'b0;
      pc_we_q   <= 1'b0;
      rd_sel_q  <= '0;
      rd_data_q <= '0;
      pc_data_q <= '0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      wr_rd_q   <= 1'b0;
      wr_pc_q   <= 1'b0;
      is_read_q <= 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_we_q   <= rd_we_d;
      pc_we_q   <= pc_we_d;
      rd_sel_q  <= rd_sel_d;
      rd_data_q <= rd_data_d;
      pc_data_q <= pc_data_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      wr_rd_q   <= wr_rd_d;
      wr_pc_q   <= wr_pc_d;
      is_read_q <= is_read_d;
`ifdef MEM_WB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign bus.O_mem_req   = req_q;
  assign bus.O_mem_we    = we_q;
  assign bus.O_mem_addr  = addr_q;
  assign bus.O_mem_wdata = wdata_q;
  assign bus.O_rD_we     = rd_we_q;
  assign bus.O_rD_sel    = rd_sel_q;
  assign bus.O_rD_data   = rd_data_q;
  assign bus.O_pc_we     = pc_we_q;
  assign bus.O_pc_data   = pc_data_q;
  assign bus.O_busy      = busy_q;
  assign bus.O_fault     = fault_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed + randomized check of mem_wb_stage against an operation-level model
module tb_mem_wb_stage;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  mem_wb_if #(.DATA_W(16), .REG_SEL_W(3)) bus();
  mem_wb_stage #(.DATA_W(16), .REG_SEL_W(3), .TIMEOUT_CYCLES(TO)) dut (.I_clk(clk), .I_reset(rst), .bus(bus));
  typedef struct {
    logic [15:0] alu;
    logic [15:0] st;
    logic        wr;
    logic        wp;
    logic [1:0]  mode;
    logic [2:0]  sel;
  } op_t;
  // model: whether an operation is held, whether it is waiting on memory, and the expected outputs
  op_t         cur;
  bit          m_act = 0, m_mem = 0;
  int          m_wait = 0;
  logic        e_req = 0, e_we = 0, e_rd_we = 0, e_pc_we = 0, e_busy = 0, e_fault = 0;
  logic [15:0] e_addr = 0, e_wd = 0, e_rd = 0, e_pc = 0;
  logic [2:0]  e_sel = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_act = 0; m_mem = 0; m_wait = 0;
    e_req = 0; e_we = 0; e_rd_we = 0; e_pc_we = 0; e_busy = 0; e_fault = 0;
    e_addr = 0; e_wd = 0; e_rd = 0; e_pc = 0; e_sel = 0;
  endtask
  task automatic model_step();
    e_rd_we = 0;
    e_pc_we = 0;
    if (!m_act) begin
      if (bus.I_enable) begin
        cur = '{bus.I_alu_out, bus.I_store_data, bus.I_write_rD, bus.I_write_pc, bus.I_memory_mode, bus.I_rD_sel};
        m_act = 1;
        e_sel = cur.sel;
        e_pc  = cur.alu;
        if (cur.mode == 1 || cur.mode == 2) begin
          m_mem = 1; m_wait = 0;
          e_req = 1; e_addr = cur.alu; e_we = cur.mode == 2; e_wd = cur.st;
        end else begin
          e_rd = cur.alu; e_rd_we = cur.wr; e_pc_we = cur.wp;
        end
      end
    end else if (m_mem) begin
      if (bus.I_mem_ack) begin
        m_mem = 0; e_req = 0;
        if (cur.mode == 1) e_rd = bus.I_mem_rdata;
        e_rd_we = cur.wr; e_pc_we = cur.wp;
      end else begin
        m_wait++;
`ifdef MEM_WB_TIMEOUT_EN
        if (m_wait == TO) begin
          m_mem = 0; m_act = 0; e_req = 0; e_fault = 1;
        end
`endif
      end
    end else m_act = 0;
    e_busy = m_act;
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end
  initial forever begin
    @(posedge clk);
    #1;
    chk("mem_req", bus.O_mem_req, e_req);
    chk("mem_we", bus.O_mem_we, e_we);
    chk("mem_addr", bus.O_mem_addr, e_addr);
    chk("mem_wdata", bus.O_mem_wdata, e_wd);
    chk("rd_we", bus.O_rD_we, e_rd_we);
    chk("rd_sel", bus.O_rD_sel, e_sel);
    chk("rd_data", bus.O_rD_data, e_rd);
    chk("pc_we", bus.O_pc_we, e_pc_we);
    chk("pc_data", bus.O_pc_data, e_pc);
    chk("busy", bus.O_busy, e_busy);
    chk("fault", bus.O_fault, e_fault);
  end
  task automatic issue(input logic [1:0] mode, input logic [15:0] alu, input logic [15:0] st,
                       input logic wr, input logic wp, input logic [2:0] sel);
    @(negedge clk);
    bus.I_enable = 1; bus.I_memory_mode = mode; bus.I_alu_out = alu; bus.I_store_data = st;
    bus.I_write_rD = wr; bus.I_write_pc = wp; bus.I_rD_sel = sel;
    @(posedge clk);
    #1;
    bus.I_enable = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.I_enable = 0; bus.I_alu_out = 0; bus.I_write_rD = 0; bus.I_write_pc = 0; bus.I_memory_mode = 0;
    bus.I_rD_sel = 0; bus.I_store_data = 0; bus.I_mem_ack = 0; bus.I_mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.O_busy, 0);
    chk("reset_req", bus.O_mem_req, 0);
    @(negedge clk);
    rst = 0;
    issue(2'd0, 16'h1234, 16'h0, 1, 0, 3'd5);
    chk("nop_rd_we", bus.O_rD_we, 1);
    chk("nop_rd_sel", bus.O_rD_sel, 5);
    chk("nop_rd_data", bus.O_rD_data, 16'h1234);
    chk("nop_no_req", bus.O_mem_req, 0);
    tick();
    chk("nop_pulse_end", bus.O_rD_we, 0);
    chk("nop_idle", bus.O_busy, 0);
    issue(2'd1, 16'h0040, 16'h0, 1, 0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("read_req", bus.O_mem_req, 1);
      chk("read_addr", bus.O_mem_addr, 16'h0040);
      chk("read_we", bus.O_mem_we, 0);
    end
    bus.I_mem_ack = 1; bus.I_mem_rdata = 16'hBEEF;
    tick();
    bus.I_mem_ack = 0;
    chk("read_req_drop", bus.O_mem_req, 0);
    chk("read_rd_we", bus.O_rD_we, 1);
    chk("read_rd_data", bus.O_rD_data, 16'hBEEF);
    tick();
    chk("read_pulse_end", bus.O_rD_we, 0);
    issue(2'd2, 16'h0010, 16'hA5A5, 0, 0, 3'd1);
    chk("write_we", bus.O_mem_we, 1);
    chk("write_wdata", bus.O_mem_wdata, 16'hA5A5);
    bus.I_mem_ack = 1; bus.I_mem_rdata = 16'h1111;
    tick();
    bus.I_mem_ack = 0;
    chk("write_no_rd_we", bus.O_rD_we, 0);
    chk("write_rd_kept", bus.O_rD_data, 16'hBEEF);
    chk("write_wb_busy", bus.O_busy, 1);
    tick();
    issue(2'd0, 16'h0102, 16'h0, 0, 1, 3'd0);
    chk("jump_pc_we", bus.O_pc_we, 1);
    chk("jump_pc_data", bus.O_pc_data, 16'h0102);
    bus.I_enable = 1; bus.I_alu_out = 16'h7777;
    tick();
    bus.I_enable = 0;
    chk("jump_ignored_we", bus.O_pc_we, 0);
    chk("jump_ignored_pc", bus.O_pc_data, 16'h0102);
    chk("jump_ignored_busy", bus.O_busy, 0);
    issue(2'd3, 16'h0055, 16'h0, 1, 0, 3'd6);
    chk("mode3_no_req", bus.O_mem_req, 0);
    chk("mode3_rd_data", bus.O_rD_data, 16'h0055);
    tick();
    issue(2'd1, 16'h0200, 16'h0, 1, 1, 3'd4);
    chk("rst_pre_req", bus.O_mem_req, 1);
    #2 rst = 1;
    #1;
    chk("rst_req_drop", bus.O_mem_req, 0);
    chk("rst_busy_drop", bus.O_busy, 0);
    @(negedge clk);
    rst = 0;
    bus.I_mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_wb", bus.O_rD_we | bus.O_pc_we, 0);
    end
    bus.I_mem_ack = 0;
`ifdef MEM_WB_TIMEOUT_EN
    issue(2'd1, 16'h0300, 16'h0, 1, 1, 3'd7);
    for (int i = 0; i < TO; i++) begin
      if (i > 0) tick();
      chk("to_req", bus.O_mem_req, 1);
    end
    tick();
    chk("to_req_drop", bus.O_mem_req, 0);
    chk("to_fault", bus.O_fault, 1);
    chk("to_no_wb", bus.O_rD_we | bus.O_pc_we, 0);
    tick();
    chk("to_fault_sticky", bus.O_fault, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.I_enable      = ($urandom % 3) != 0;
      bus.I_alu_out     = 16'($urandom);
      bus.I_store_data  = 16'($urandom);
      bus.I_write_rD    = 1'($urandom);
      bus.I_write_pc    = 1'($urandom);
      bus.I_memory_mode = 2'($urandom);
      bus.I_rD_sel      = 3'($urandom);
      bus.I_mem_ack     = ($urandom % 4) == 0;
      bus.I_mem_rdata   = 16'($urandom);
    end
    @(negedge clk);
    bus.I_enable = 0;
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
